stream_capture: RTL and testbench
=================================

STREAM_CAPTURE -- requirements
Module: stream_capture

Interface
REQ-001 SHALL have parameter WORDLENGTH, default 14, sample width in bits (signed fixed point).
REQ-002 SHALL have parameter FRACTIONAL_LENGTH, default 6, fractional bits; carried only, never interpreted.
REQ-003 SHALL have parameter DEPTH, default 128, samples per capture; power of two, >= 4.
REQ-004 SHALL use one clock, with reset asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 arstn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle arm request for a capture.
REQ-008 s_tdata  input  WORDLENGTH  input sample, bit layout [WORDLENGTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH].
REQ-009 s_tvalid  input  1  s_tdata valid; no tready, so the source cannot be stalled.
REQ-010 m_tdata  output  WORDLENGTH  readback sample, same layout as s_tdata.
REQ-011 m_tvalid  output  1  m_tdata valid.
REQ-012 m_tready  input  1  downstream accepts m_tdata.
REQ-013 m_tlast  output  1  marks readback sample DEPTH-1.
REQ-014 busy  output  1  high in CAPTURE or DRAIN.
REQ-015 done  output  1  one-cycle pulse after the last readback transfer.
REQ-016 dropped  output  1  sticky: s_tvalid seen outside CAPTURE.

Function
REQ-017 SHALL implement FSM states IDLE, CAPTURE, DRAIN.
REQ-018 IDLE: start=1 -> CAPTURE next cycle; write pointer cleared to 0.
REQ-019 CAPTURE: each cycle with s_tvalid=1 writes s_tdata verbatim to mem[wr_ptr]; wr_ptr increments; gaps in s_tvalid are allowed.
REQ-020 CAPTURE: write of index DEPTH-1 -> DRAIN next cycle; wr_ptr wraps to 0.
REQ-021 DRAIN: m_tvalid SHALL first assert on the 2nd rising edge after the edge writing index DEPTH-1, presenting mem[0].
REQ-022 Transfer = m_tvalid & m_tready; the read index advances only on a transfer; samples SHALL leave in write order, no loss, no duplication.
REQ-023 With m_tready held high, DRAIN SHALL sustain one transfer per cycle (DEPTH transfers in DEPTH consecutive cycles).
REQ-024 While m_tvalid=1 and m_tready=0, m_tdata and m_tlast SHALL hold stable.
REQ-025 m_tlast=1 only while m_tdata carries index DEPTH-1.
REQ-026 On the transfer with m_tlast=1: m_tvalid deasserts next cycle, done=1 for exactly that next cycle, FSM -> IDLE.
REQ-027 busy SHALL equal (state != IDLE), registered.
REQ-028 start in CAPTURE or DRAIN SHALL be ignored.
REQ-029 s_tvalid on the same cycle as start in IDLE SHALL NOT be captured; it sets dropped.
REQ-030 s_tvalid in IDLE or DRAIN SHALL set dropped; dropped clears only on the next accepted start or on reset.
REQ-031 Storage SHALL be DEPTH x WORDLENGTH, inferable as simple dual-port RAM (one write port, one registered read port).

Reset
REQ-032 arstn=0 SHALL immediately force state IDLE, pointers 0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, dropped=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset mid-CAPTURE or mid-DRAIN SHALL abandon the operation; after release the block SHALL accept a new start with no residue.

Verification
REQ-035 Reset: assert arstn=0 asynchronously, between clock edges -> all outputs 0 before the next edge; busy=0.
REQ-036 Basic: start, then s_tdata=0..127 on 128 consecutive cycles, m_tready=1 -> m_tdata 0..127 on 128 consecutive cycles; m_tlast only on 127; done pulse once; dropped=0.
REQ-037 Gapped input: s_tvalid every 3rd cycle, values -64..63 (signed) -> identical ordered readback; DRAIN entered only after 128 writes.
REQ-038 Backpressure: m_tready pseudo-random 50% -> exactly 128 transfers, in order; m_tdata stable across every stall cycle.
REQ-039 Protocol edges: s_tvalid=1 in IDLE -> dropped=1 and nothing written; start during DRAIN -> ignored, readback completes unchanged.
REQ-040 Reset mid-DRAIN after transfer 40 -> outputs 0 immediately; new start plus 128 samples 1000..1127 -> readback 1000..1127.

Source files
------------

// File: rtl/stream_capture.sv
// Captures DEPTH samples into a simple dual-port RAM, then streams them back in write order.
// First readback beat lands two edges after the final write; readback honours m_tready, the capture side cannot stall.
module stream_capture #(
  parameter int WORDLENGTH        = 14,
  parameter int FRACTIONAL_LENGTH = 6,
  parameter int DEPTH             = 128
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  start,
  input  logic [WORDLENGTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic [WORDLENGTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  dropped
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("stream_capture: DEPTH must be a power of two and at least 4");
    end
    if (FRACTIONAL_LENGTH < 0 || FRACTIONAL_LENGTH > WORDLENGTH) begin : g_bad_frac
      $error("stream_capture: FRACTIONAL_LENGTH must lie within 0..WORDLENGTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                state;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  primed;
  logic [WORDLENGTH-1:0] mem [DEPTH];
  logic [WORDLENGTH-1:0] rd_data;
  logic                  wr_en;
  logic                  rd_en;
  logic                  xfer;

  assign xfer  = m_tvalid & m_tready;
  assign wr_en = (state == CAPTURE) & s_tvalid;
  // Fetch the first word once primed, then one more per accepted non-last beat.
  assign rd_en = (state == DRAIN) & primed & (~m_tvalid | (m_tready & ~m_tlast));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // Read register carries no reset so it maps onto RAM; gating gives zero data while idle or in reset.
  assign m_tdata = m_tvalid ? rd_data : '0;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      primed   <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CAPTURE;
            busy    <= 1'b1;
            wr_ptr  <= '0;
            dropped <= s_tvalid;
          end else if (s_tvalid) begin
            dropped <= 1'b1;
          end
        end
        CAPTURE: begin
          if (s_tvalid) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_ptr == LAST_IDX) begin
              state  <= DRAIN;
              rd_ptr <= '0;
              primed <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (s_tvalid) begin
            dropped <= 1'b1;
          end
          primed <= 1'b1;
          if (rd_en) begin
            m_tvalid <= 1'b1;
            m_tlast  <= (rd_ptr == LAST_IDX);
            rd_ptr   <= rd_ptr + AW'(1);
          end else if (xfer && m_tlast) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_capture.sv
// Randomized directed bench for stream_capture; expected readback comes from a queue of the samples sent while capturing.
module tb_stream_capture;
  localparam int W = 14;
  localparam int F = 6;
  localparam int D = 128;

  logic         clk = 1'b0;
  logic         arstn;
  logic         start;
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         busy;
  logic         done;
  logic         dropped;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  stream_capture #(.WORDLENGTH(W), .FRACTIONAL_LENGTH(F), .DEPTH(D)) dut (
    .clk      (clk),
    .arstn    (arstn),
    .start    (start),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .busy     (busy),
    .done     (done),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] sample_val(input int dmode, input int k, input int base);
    case (dmode)
      0:       return W'(base + k);
      1:       return W'(k - 64);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_mvalid"}, m_tvalid, 0);
    chk({tag, "_mlast"}, m_tlast, 0);
    chk({tag, "_mdata"}, m_tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dropped"}, dropped, 0);
  endtask

  // vmode: 0 every cycle, 1 every 3rd cycle, 2 random gaps. Ends just after the final write edge.
  task automatic capture(input int vmode, input int dmode, input int base,
                         input bit sv_on_start, input bit start_noise);
    int sent = 0;
    int cyc = 0;
    bit v;
    logic [W-1:0] val;
    start = 1'b1;
    s_tvalid = sv_on_start;
    s_tdata = W'($urandom);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("dropped_after_start", dropped, sv_on_start);
    while (sent < D && cyc < 8 * D) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(3) != 0);
      endcase
      s_tvalid = v;
      start = start_noise && ($urandom_range(9) == 0);
      if (v) begin
        val = sample_val(dmode, sent, base);
        s_tdata = val;
        exp_q.push_back(val);
        sent++;
      end else begin
        s_tdata = W'($urandom);
      end
      step();
      cyc++;
      chk("no_early_drain", m_tvalid, 0);
    end
    s_tvalid = 1'b0;
    start = 1'b0;
    if (sent < D) chk("capture_timeout", sent, D);
  endtask

  task automatic drain(input int rdy_pct, input int stop_at, input bit noise);
    int n = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit r;
    logic [W-1:0] held_d;
    logic held_l;
    logic [W-1:0] exp_val;
    m_tready = 1'b0;
    step();
    chk("lat_edge1", m_tvalid, 0);
    step();
    chk("lat_edge2", m_tvalid, 1);
    chk("busy_drain", busy, 1);
    while (n < stop_at && cyc < 16 * D) begin
      if (stalled) begin
        chk("stall_vld", m_tvalid, 1);
        chk("stall_data", m_tdata, held_d);
        chk("stall_last", m_tlast, held_l);
      end
      if (m_tvalid) chk("tlast_pos", m_tlast, (n == D - 1));
      chk("no_done_mid", done, 0);
      r = ($urandom_range(99) < rdy_pct);
      m_tready = r;
      start = noise && (n == 10);
      s_tvalid = noise && (n == 10);
      s_tdata = W'($urandom);
      if (m_tvalid && r) begin
        exp_val = exp_q.pop_front();
        chk("rd_data", m_tdata, exp_val);
        n++;
        stalled = 1'b0;
      end else begin
        stalled = m_tvalid;
        held_d = m_tdata;
        held_l = m_tlast;
      end
      if (rdy_pct == 100) chk("sustain", m_tvalid, 1);
      step();
      cyc++;
    end
    m_tready = 1'b0;
    start = 1'b0;
    s_tvalid = 1'b0;
    if (n < stop_at) begin
      chk("drain_timeout", n, stop_at);
    end else if (n == D) begin
      chk("vld_after_last", m_tvalid, 0);
      chk("done_pulse", done, 1);
      chk("busy_idle", busy, 0);
      chk("exp_empty", exp_q.size(), 0);
      step();
      chk("done_once", done, 0);
    end
  endtask

  initial begin
    arstn = 1'b1;
    start = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    m_tready = 1'b0;

    // asynchronous reset asserted between edges
    #3 arstn = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(posedge clk);
    #2 arstn = 1'b1;
    step();

    // basic: 0..127 back-to-back, ready always high
    capture(0, 0, 0, 1'b0, 1'b0);
    drain(100, D, 1'b0);
    chk("basic_dropped", dropped, 0);

    // gapped input, signed -64..63
    capture(1, 1, 0, 1'b0, 1'b0);
    drain(100, D, 1'b0);
    chk("gap_dropped", dropped, 0);

    // random data, random gaps, start noise while capturing, 50% backpressure
    capture(2, 2, 0, 1'b0, 1'b1);
    drain(50, D, 1'b0);
    chk("bp_dropped", dropped, 0);

    // s_tvalid in IDLE sets dropped; start with s_tvalid same cycle; start and s_tvalid during DRAIN
    s_tvalid = 1'b1;
    s_tdata = W'($urandom);
    repeat (3) step();
    s_tvalid = 1'b0;
    chk("idle_dropped", dropped, 1);
    chk("idle_busy", busy, 0);
    chk("idle_mvalid", m_tvalid, 0);
    capture(0, 2, 0, 1'b1, 1'b0);
    drain(70, D, 1'b1);
    chk("drain_dropped", dropped, 1);

    // reset after 40 transfers, then a clean capture of 1000..1127
    capture(0, 0, 0, 1'b0, 1'b0);
    drain(100, 40, 1'b0);
    #2 arstn = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    #2 arstn = 1'b1;
    exp_q.delete();
    step();
    chk("post_rst_busy", busy, 0);
    capture(0, 0, 1000, 1'b0, 1'b0);
    drain(100, D, 1'b0);
    chk("post_rst_dropped", dropped, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
